idex_operand_stage: RTL and testbench

- Sits between decode and the ALU in the 5-stage pipeline.
- Registers the decoded instruction (ID/EX latch) and drives the ALU `aluop`, `porta` and `portb` inputs.
- Forwards results from EX/MEM and MEM/WB onto the operands.
- Detects load-use hazards and inserts bubbles; honours external stall and flush.

---
 rtl/idex_operand_stage.sv | 133 +++++++++++++
 tb/tb_idex_operand_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline latch with operand forwarding and load-use hazard detection.
// Feeds aluop/porta/portb to the ALU and the forwarded rt value to the store path.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module idex_operand_stage
  import cpu_types_pkg::*;
#(
  parameter int REGBITS = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               id_valid,
  input  aluop_t             id_aluop,
  input  word_t              id_rdat1,
  input  word_t              id_rdat2,
  input  word_t              id_imm,
  input  logic               id_alusrc,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [REGBITS-1:0] id_dest,
  input  logic               id_regwr,
  input  logic               id_memread,
  input  logic               exmem_regwr,
  input  logic [REGBITS-1:0] exmem_dest,
  input  word_t              exmem_result,
  input  logic               memwb_regwr,
  input  logic [REGBITS-1:0] memwb_dest,
  input  word_t              memwb_wdat,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output aluop_t             aluop,
  output word_t              porta,
  output word_t              portb,
  output word_t              ex_storedata,
  output logic [REGBITS-1:0] ex_dest,
  output logic               ex_regwr,
  output logic               ex_memread,
  output logic               hazard_stall
);

  logic               valid_q;
  aluop_t             aluop_q;
  word_t              op1_q;
  word_t              op2_q;
  word_t              imm_q;
  logic               alusrc_q;
  logic [REGBITS-1:0] rs_q;
  logic [REGBITS-1:0] rt_q;
  logic [REGBITS-1:0] dest_q;
  logic               regwr_q;
  logic               memread_q;

  word_t fwda;
  word_t fwdb;

  // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded.
  always_comb begin
    fwda = op1_q;
    if (exmem_regwr && (exmem_dest == rs_q) && (rs_q != '0))
      fwda = exmem_result;
    else if (memwb_regwr && (memwb_dest == rs_q) && (rs_q != '0))
      fwda = memwb_wdat;
  end

  always_comb begin
    fwdb = op2_q;
    if (exmem_regwr && (exmem_dest == rt_q) && (rt_q != '0))
      fwdb = exmem_result;
    else if (memwb_regwr && (memwb_dest == rt_q) && (rt_q != '0))
      fwdb = memwb_wdat;
  end

  // Conservative: rt is compared even for instructions that do not read it.
  assign hazard_stall = valid_q & memread_q & (dest_q != '0) & id_valid &
                        ((dest_q == id_rs) | (dest_q == id_rt));

  always_ff @(posedge CLK) begin
    if (RST || flush || (!stall && hazard_stall)) begin
      valid_q   <= 1'b0;
      aluop_q   <= ALU_SLL;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      alusrc_q  <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      dest_q    <= '0;
      regwr_q   <= 1'b0;
      memread_q <= 1'b0;
    end else if (stall) begin
      // Capture forwarded values so they survive the producer retiring mid-hold.
      op1_q <= fwda;
      op2_q <= fwdb;
    end else begin
      valid_q   <= id_valid;
      aluop_q   <= id_aluop;
      op1_q     <= id_rdat1;
      op2_q     <= id_rdat2;
      imm_q     <= id_imm;
      alusrc_q  <= id_alusrc;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      dest_q    <= id_dest;
      regwr_q   <= id_regwr & id_valid;
      memread_q <= id_memread & id_valid;
    end
  end

  assign ex_valid     = valid_q;
  assign aluop        = aluop_q;
  assign porta        = fwda;
  assign portb        = alusrc_q ? imm_q : fwdb;
  assign ex_storedata = fwdb;
  assign ex_dest      = dest_q;
  assign ex_regwr     = regwr_q;
  assign ex_memread   = memread_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: reset, forwarding priority, immediate
// select, load-use bubble, stall capture, and flush/stall/hazard precedence.
module tb_idex_operand_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid;
  aluop_t      id_aluop;
  word_t       id_rdat1, id_rdat2, id_imm;
  logic        id_alusrc;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_regwr, id_memread;
  logic        exmem_regwr;
  logic [4:0]  exmem_dest;
  word_t       exmem_result;
  logic        memwb_regwr;
  logic [4:0]  memwb_dest;
  word_t       memwb_wdat;
  logic        stall, flush;
  logic        ex_valid;
  aluop_t      aluop;
  word_t       porta, portb, ex_storedata;
  logic [4:0]  ex_dest;
  logic        ex_regwr, ex_memread, hazard_stall;

  int checks = 0;
  int failures = 0;

  idex_operand_stage #(.REGBITS(5)) dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_regwr(id_regwr), .id_memread(id_memread),
    .exmem_regwr(exmem_regwr), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_regwr(memwb_regwr), .memwb_dest(memwb_dest), .memwb_wdat(memwb_wdat),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .aluop(aluop), .porta(porta), .portb(portb),
    .ex_storedata(ex_storedata), .ex_dest(ex_dest), .ex_regwr(ex_regwr),
    .ex_memread(ex_memread), .hazard_stall(hazard_stall)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_aluop = ALU_SLL; id_rdat1 = 0; id_rdat2 = 0; id_imm = 0;
    id_alusrc = 0; id_rs = 0; id_rt = 0; id_dest = 0; id_regwr = 0; id_memread = 0;
    exmem_regwr = 0; exmem_dest = 0; exmem_result = 0;
    memwb_regwr = 0; memwb_dest = 0; memwb_wdat = 0;
    stall = 0; flush = 0;
  endtask

  task automatic set_id(input aluop_t op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dest, input word_t r1, input word_t r2,
                        input word_t imm, input logic alusrc, input logic memread);
    id_valid = 1; id_aluop = op; id_rs = rs; id_rt = rt; id_dest = dest;
    id_rdat1 = r1; id_rdat2 = r2; id_imm = imm; id_alusrc = alusrc;
    id_regwr = 1; id_memread = memread;
  endtask

  initial begin
    clear_inputs();
    RST = 1;
    // Reset with random decode inputs but no write-back activity.
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
      id_dest = 5'($urandom); id_rdat1 = $urandom; id_rdat2 = $urandom;
      id_imm = $urandom; id_regwr = 1'($urandom); id_memread = 1'($urandom);
      tick();
    end
    #1;
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_regwr", 32'(ex_regwr), 0);
    check("rst_memread", 32'(ex_memread), 0);
    check("rst_hazard", 32'(hazard_stall), 0);
    check("rst_porta", porta, 0);
    check("rst_portb", portb, 0);
    check("rst_store", ex_storedata, 0);
    check("rst_aluop", 32'(aluop), 0);
    check("rst_dest", 32'(ex_dest), 0);
    RST = 0;
    clear_inputs();

    // Forwarding priority on rs.
    set_id(ALU_ADD, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    check("lat_valid", 32'(ex_valid), 1);
    check("lat_aluop", 32'(aluop), 32'(ALU_ADD));
    check("lat_dest", 32'(ex_dest), 9);
    check("lat_regwr", 32'(ex_regwr), 1);
    check("lat_porta", porta, 32'h11);
    check("lat_portb", portb, 32'h22);
    exmem_regwr = 1; exmem_dest = 3; exmem_result = 32'hAA;
    memwb_regwr = 1; memwb_dest = 3; memwb_wdat = 32'hBB;
    #1;
    check("fwd_exmem_wins", porta, 32'hAA);
    check("fwd_portb_untouched", portb, 32'h22);
    exmem_regwr = 0;
    #1;
    check("fwd_memwb", porta, 32'hBB);
    memwb_dest = 4;
    #1;
    check("fwd_memwb_rt", portb, 32'hBB);
    check("fwd_memwb_rt_a", porta, 32'h11);
    clear_inputs();

    set_id(ALU_OR, 5'd0, 5'd0, 5'd9, 32'h11, 32'h33, 32'h0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    exmem_regwr = 1; exmem_dest = 0; exmem_result = 32'hAA;
    memwb_regwr = 1; memwb_dest = 0; memwb_wdat = 32'hBB;
    #1;
    check("fwd_r0_a", porta, 32'h11);
    check("fwd_r0_b", portb, 32'h33);
    clear_inputs();

    // Immediate select with rt forwarded.
    set_id(ALU_ADD, 5'd2, 5'd4, 5'd6, 32'h1, 32'h99, 32'hFFFF_FFF0, 1'b1, 1'b0);
    tick();
    clear_inputs();
    exmem_regwr = 1; exmem_dest = 4; exmem_result = 32'h55;
    #1;
    check("imm_portb", portb, 32'hFFFF_FFF0);
    check("imm_store", ex_storedata, 32'h55);
    clear_inputs();

    // Load-use: EX holds lw $8.
    set_id(ALU_ADD, 5'd1, 5'd8, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
    tick();
    check("lw_memread", 32'(ex_memread), 1);
    set_id(ALU_SUB, 5'd8, 5'd2, 5'd10, 32'h7, 32'h8, 32'h0, 1'b0, 1'b0);
    #1;
    check("lu_hazard", 32'(hazard_stall), 1);
    tick();
    check("lu_bubble_valid", 32'(ex_valid), 0);
    check("lu_bubble_regwr", 32'(ex_regwr), 0);
    check("lu_hazard_clear", 32'(hazard_stall), 0);
    tick();
    check("lu_dep_valid", 32'(ex_valid), 1);
    check("lu_dep_dest", 32'(ex_dest), 10);
    check("lu_dep_aluop", 32'(aluop), 32'(ALU_SUB));
    clear_inputs();

    // Hazard conditions that must not fire: rt match with id_valid low, dest 0.
    set_id(ALU_ADD, 5'd1, 5'd8, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
    tick();
    set_id(ALU_ADD, 5'd2, 5'd8, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("hz_rt_match", 32'(hazard_stall), 1);
    id_valid = 0;
    #1;
    check("hz_id_invalid", 32'(hazard_stall), 0);
    id_valid = 1;
    // stall beats hazard: content held, hazard stays asserted.
    stall = 1;
    tick();
    check("st_hz_valid", 32'(ex_valid), 1);
    check("st_hz_memread", 32'(ex_memread), 1);
    check("st_hz_dest", 32'(ex_dest), 8);
    check("st_hz_hazard", 32'(hazard_stall), 1);
    // RST mid-stall/hazard clears everything.
    RST = 1;
    tick();
    RST = 0;
    check("rst_mid_valid", 32'(ex_valid), 0);
    check("rst_mid_hazard", 32'(hazard_stall), 0);
    clear_inputs();

    set_id(ALU_ADD, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    set_id(ALU_ADD, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("hz_dest0", 32'(hazard_stall), 0);
    clear_inputs();

    // Stall capture of a transient forward.
    set_id(ALU_AND, 5'd5, 5'd6, 5'd7, 32'h0, 32'h66, 32'h0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    stall = 1;
    tick();
    memwb_regwr = 1; memwb_dest = 5; memwb_wdat = 32'h1234;
    tick();
    memwb_regwr = 0; memwb_wdat = 0;
    stall = 0;
    #1;
    check("stall_cap_porta", porta, 32'h1234);
    check("stall_cap_portb", portb, 32'h66);
    check("stall_cap_dest", 32'(ex_dest), 7);

    // flush beats stall.
    set_id(ALU_XOR, 5'd1, 5'd2, 5'd12, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0);
    tick();
    check("pre_flush_valid", 32'(ex_valid), 1);
    flush = 1; stall = 1;
    tick();
    check("flush_valid", 32'(ex_valid), 0);
    check("flush_regwr", 32'(ex_regwr), 0);
    clear_inputs();

    // id_valid low loads a bubble with regwr/memread qualified.
    set_id(ALU_ADD, 5'd1, 5'd2, 5'd13, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    id_valid = 0;
    tick();
    check("inv_valid", 32'(ex_valid), 0);
    check("inv_regwr", 32'(ex_regwr), 0);
    check("inv_memread", 32'(ex_memread), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
